cycle_print_engine: RTL

//  Parametrised successor to the fixed 64-node/2-digit cycle printer. After Bellman-Ford finishes, it scans vertex

---
 rtl/cycle_print_engine.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cycle_print_engine.sv
// cycle_print_engine: scans vertex memory for flagged (negative-cycle) vertices
// and prints each predecessor cycle once into the character frame buffer as
// N-digit decimal node ids separated by arrows, clearing flags as it walks.
module cycle_print_engine #(
    parameter int unsigned NODES    = 64,
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned COLS     = 40,
    parameter int unsigned ROWS     = 30,
    parameter int unsigned CHAR_W   = 6,
    parameter int unsigned CH_BLANK = 10,
    parameter int unsigned CH_ARROW = 37,
    parameter int unsigned CH_ABORT = 38
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(NODES)+WEIGHT_W:0]  mem_rdata,
    output logic [$clog2(NODES)-1:0]         mem_addr,
    output logic [$clog2(NODES)+WEIGHT_W:0]  mem_wdata,
    output logic                             mem_we,
    output logic [CHAR_W-1:0]                frame_char,
    output logic [$clog2(COLS)-1:0]          frame_x,
    output logic [$clog2(ROWS)-1:0]          frame_y,
    output logic                             frame_we,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NODES):0]           cycles_found
);

    localparam int unsigned NODE_W = $clog2(NODES);
    localparam int unsigned LOW_W  = NODE_W + WEIGHT_W;
    localparam int unsigned XW     = $clog2(COLS);
    localparam int unsigned YW     = $clog2(ROWS);
    localparam int unsigned DI_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN_RD, S_SCAN_CHK, S_NEWLINE, S_LOAD, S_LATCH,
        S_CONV, S_EMIT, S_CLEAR, S_ARROW, S_ABORT, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [NODE_W-1:0]        v_q, v_d, k_q, k_d, cur_q, cur_d, rem_q, rem_d;
    logic [LOW_W-1:0]         ent_q, ent_d;
    logic [NODE_W:0]          hops_q, hops_d, cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [DI_W-1:0]          didx_q, didx_d;
    logic                     seen_q, seen_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;

    logic [NODE_W-1:0]        nxt, rem_n;
    logic [31:0]              pw;
    logic [YW-1:0]            y_inc;
    logic [NODE_W:0]          hops_inc;
    logic                     adv;

    function automatic logic [31:0] pow10(input logic [DI_W-1:0] d);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (i < 32'(d)) p = p * 32'd10;
        return p;
    endfunction

    assign nxt          = ent_q[LOW_W-1 -: NODE_W];
    assign mem_wdata    = {1'b0, ent_q};
    assign frame_x      = x_q;
    assign frame_y      = y_q;
    assign cycles_found = cnt_q;

    // State and datapath registers; reset abandons any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            k_q     <= '0;
            cur_q   <= '0;
            rem_q   <= '0;
            ent_q   <= '0;
            hops_q  <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            didx_q  <= '0;
            seen_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= YW'(ROWS - 1);
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            k_q     <= k_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            ent_q   <= ent_d;
            hops_q  <= hops_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            didx_q  <= didx_d;
            seen_q  <= seen_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Next-state, datapath updates and memory/frame strobes.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        k_d        = k_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        ent_d      = ent_q;
        hops_d     = hops_q;
        cnt_d      = cnt_q;
        dig_d      = dig_q;
        didx_d     = didx_q;
        seen_d     = seen_q;
        x_d        = x_q;
        y_d        = y_q;
        mem_addr   = v_q;
        mem_we     = 1'b0;
        frame_we   = 1'b0;
        frame_char = '0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        pw         = pow10(didx_q);
        rem_n      = rem_q;
        y_inc      = (y_q == YW'(ROWS - 1)) ? '0 : y_q + 1'b1;
        hops_inc   = hops_q + 1'b1;
        adv        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    v_d     = '0;
                    cnt_d   = '0;
                    state_d = S_SCAN_RD;
                end
            end
            S_SCAN_RD: begin
                mem_addr = v_q;
                state_d  = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (mem_rdata[LOW_W]) begin
                    k_d     = v_q;
                    cur_d   = v_q;
                    state_d = S_NEWLINE;
                end else begin
                    adv = 1'b1;
                end
            end
            S_NEWLINE: begin
                x_d     = '0;
                y_d     = y_inc;
                hops_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                mem_addr = cur_q;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                ent_d   = mem_rdata[LOW_W-1:0];
                rem_d   = cur_q;
                dig_d   = '0;
                didx_d  = DI_W'(DIGITS - 1);
                state_d = S_CONV;
            end
            S_CONV: begin
                // Subtract and digit advance share a cycle, so each digit costs
                // max(1, value) cycles and a node never exceeds 9*DIGITS.
                if (32'(rem_q) >= pw) begin
                    rem_n          = rem_q - pw[NODE_W-1:0];
                    dig_d[didx_q]  = dig_q[didx_q] + 4'd1;
                end
                rem_d = rem_n;
                if (32'(rem_n) < pw) begin
                    if (didx_q == '0) begin
                        didx_d  = DI_W'(DIGITS - 1);
                        seen_d  = 1'b0;
                        state_d = S_EMIT;
                    end else begin
                        didx_d = didx_q - 1'b1;
                    end
                end
            end
            S_EMIT: begin
                frame_we = 1'b1;
                if (dig_q[didx_q] != 4'd0 || seen_q || didx_q == '0) begin
                    frame_char = CHAR_W'(dig_q[didx_q]);
                    if (dig_q[didx_q] != 4'd0) seen_d = 1'b1;
                end else begin
                    frame_char = CHAR_W'(CH_BLANK);
                end
                if (didx_q == '0) state_d = S_CLEAR;
                else              didx_d  = didx_q - 1'b1;
            end
            S_CLEAR: begin
                mem_addr = cur_q;
                mem_we   = 1'b1;
                if (nxt == k_q) begin
                    cnt_d = cnt_q + 1'b1;
                    adv   = 1'b1;
                end else begin
                    hops_d  = hops_inc;
                    state_d = (hops_inc == (NODE_W + 1)'(NODES)) ? S_ABORT : S_ARROW;
                end
            end
            S_ARROW: begin
                frame_we   = 1'b1;
                frame_char = CHAR_W'(CH_ARROW);
                cur_d      = nxt;
                state_d    = S_LOAD;
            end
            S_ABORT: begin
                frame_we   = 1'b1;
                frame_char = CHAR_W'(CH_ABORT);
                adv        = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (v_q == NODE_W'(NODES - 1)) begin
                state_d = S_DONE;
            end else begin
                v_d     = v_q + 1'b1;
                state_d = S_SCAN_RD;
            end
        end

        if (frame_we) begin
            if (x_q == XW'(COLS - 1)) begin
                x_d = '0;
                y_d = y_inc;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

endmodule
